qspi_master_ctrl: RTL and testbench

- Quad-SPI initiator: the host end of the sensor-RAM QSPI link.
- Drives SCK, CS and four IO lines, issuing one write or read burst per request: command, 32-bit address, optional dummy, N data bytes.
- Used by the bring-up board and loopback bench to exercise the sensor-RAM QSPI responder.
- Sits behind the top-level IOBUFs: the tri-state split is exposed as o/oe/i.

---
 rtl/qspi_master_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_qspi_master_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_master_ctrl.sv
// qspi_master_ctrl: Quad-SPI initiator for the sensor-RAM link.
// Each accepted request runs one burst: command byte, 32-bit address,
// optional dummy cycles (reads only), then len data bytes, MSB nibble first.
//
// Ports
//   clk, Rst                  system clock, async active-high reset
//   start/wr/addr/len         burst request (sampled with start when idle)
//   tx_data, tx_req           write byte, latched in the cycle tx_req=1
//   rx_data, rx_valid         received byte and its one-cycle strobe
//   busy, done                burst in flight / one-cycle end-of-burst pulse
//   qspi_clk, qspi_cs         SCK (mode 0, idle low), chip select (active low)
//   qspi_io_o/oe/i            IO nibble split for external tri-state buffers
module qspi_master_ctrl #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 2,
  parameter int unsigned LEN_W        = 8,
  parameter logic [7:0]  CMD_WR       = 8'h32,
  parameter logic [7:0]  CMD_RD       = 8'h6B
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  output logic             tx_req,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             qspi_clk,
  output logic             qspi_cs,
  output logic [3:0]       qspi_io_o,
  output logic [3:0]       qspi_io_oe,
  input  logic [3:0]       qspi_io_i
);

  // cyc holds "SCK cycles left in this state minus one"; it must fit both
  // the 2*len-1 data count and the fixed command/address/dummy counts.
  localparam int unsigned CW        = (LEN_W + 1 > 8) ? LEN_W + 1 : 8;
  localparam logic [7:0]  DIV_RLD   = 8'(CLK_DIV - 1);
  localparam logic [CW-1:0] DUMMY_RLD = CW'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, CS_HOLD, CS_GAP
  } state_t;

  state_t            state, state_n;
  logic [7:0]        div_cnt;
  logic [CW-1:0]     cyc;
  logic [CW-1:0]     data_cyc;
  logic [35:0]       sh;        // command low nibble + address, still to send
  logic              wr_q;
  logic [LEN_W-1:0]  len_q;
  logic [3:0]        tx_lo;
  logic [3:0]        rx_hi;
  logic              tick, sck_act, rise, fall, last, accept;

  always_comb begin
    tick     = (div_cnt == 8'd0);
    sck_act  = (state == CMD) || (state == ADDR) || (state == DUMMY) ||
               (state == WDATA) || (state == RDATA);
    rise     = tick && sck_act && !qspi_clk;
    fall     = tick && sck_act && qspi_clk;
    last     = (cyc == '0);
    accept   = (state == IDLE) && start && !busy && (len != '0);
    data_cyc = CW'({len_q, 1'b0}) - CW'(1);
    state_n  = state;
    tx_req   = 1'b0;
    case (state)
      IDLE:     if (accept) state_n = CS_SETUP;
      CS_SETUP: if (tick) state_n = CMD;
      CMD:      if (fall && last) state_n = ADDR;
      ADDR:
        if (fall && last) begin
          if (wr_q) begin
            state_n = WDATA;
            tx_req  = 1'b1;
          end else if (DUMMY_CYCLES > 0) begin
            state_n = DUMMY;
          end else begin
            state_n = RDATA;
          end
        end
      DUMMY:    if (fall && last) state_n = RDATA;
      WDATA:
        if (fall) begin
          if (last) state_n = CS_HOLD;
          // cyc even (and not last) means the next SCK cycle carries a high nibble
          else if (!cyc[0]) tx_req = 1'b1;
        end
      RDATA:    if (fall && last) state_n = CS_HOLD;
      CS_HOLD:  if (tick) state_n = CS_GAP;
      CS_GAP:   if (tick) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      div_cnt    <= DIV_RLD;
      cyc        <= '0;
      sh         <= '0;
      wr_q       <= 1'b0;
      len_q      <= '0;
      tx_lo      <= 4'h0;
      rx_hi      <= 4'h0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      qspi_clk   <= 1'b0;
      qspi_cs    <= 1'b1;
      qspi_io_o  <= 4'h0;
      qspi_io_oe <= 4'h0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE || tick) div_cnt <= DIV_RLD;
      else                       div_cnt <= div_cnt - 8'd1;
      if (sck_act && tick) qspi_clk <= ~qspi_clk;

      case (state)
        IDLE: begin
          // busy drops one cycle after done so a start in the done cycle is ignored
          busy <= 1'b0;
          if (accept) begin
            busy       <= 1'b1;
            wr_q       <= wr;
            len_q      <= len;
            qspi_cs    <= 1'b0;
            qspi_io_oe <= 4'hF;
            qspi_io_o  <= wr ? CMD_WR[7:4] : CMD_RD[7:4];
            sh         <= {(wr ? CMD_WR[3:0] : CMD_RD[3:0]), addr};
            cyc        <= CW'(1);
          end
        end
        CS_SETUP: if (tick) qspi_clk <= 1'b1;
        CMD:
          if (fall) begin
            qspi_io_o <= sh[35:32];
            sh        <= {sh[31:0], 4'h0};
            cyc       <= last ? CW'(7) : cyc - CW'(1);
          end
        ADDR:
          if (fall) begin
            if (!last) begin
              qspi_io_o <= sh[35:32];
              sh        <= {sh[31:0], 4'h0};
              cyc       <= cyc - CW'(1);
            end else if (wr_q) begin
              qspi_io_o <= tx_data[7:4];
              tx_lo     <= tx_data[3:0];
              cyc       <= data_cyc;
            end else begin
              qspi_io_oe <= 4'h0;
              cyc        <= (DUMMY_CYCLES > 0) ? DUMMY_RLD : data_cyc;
            end
          end
        DUMMY: if (fall) cyc <= last ? data_cyc : cyc - CW'(1);
        WDATA:
          if (fall && !last) begin
            cyc <= cyc - CW'(1);
            if (!cyc[0]) begin
              qspi_io_o <= tx_data[7:4];
              tx_lo     <= tx_data[3:0];
            end else begin
              qspi_io_o <= tx_lo;
            end
          end
        RDATA: begin
          if (rise) begin
            if (cyc[0]) rx_hi <= qspi_io_i;
            else begin
              rx_data  <= {rx_hi, qspi_io_i};
              rx_valid <= 1'b1;
            end
          end
          if (fall && !last) cyc <= cyc - CW'(1);
        end
        CS_HOLD:
          if (tick) begin
            qspi_cs    <= 1'b1;
            qspi_io_oe <= 4'h0;
          end
        CS_GAP: if (tick) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_master_ctrl.sv
`timescale 1ns/1ps
module tb_qspi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int fail_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [3:0] oe;
    bit         cn;
  } edge_t;

  // ---------------- instance A: CLK_DIV=2, DUMMY_CYCLES=2 ----------------
  logic        a_rst = 1'b1, a_start = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = '0;
  logic [7:0]  a_len = '0, a_txd, a_rxd;
  logic        a_txreq, a_rxv, a_busy, a_done, a_sck, a_cs;
  logic [3:0]  a_io_o, a_io_oe;
  logic [3:0]  a_io_i = 4'h0;

  qspi_master_ctrl #(.CLK_DIV(2), .DUMMY_CYCLES(2), .LEN_W(8)) dut_a (
    .clk(clk), .Rst(a_rst), .start(a_start), .wr(a_wr), .addr(a_addr), .len(a_len),
    .tx_data(a_txd), .tx_req(a_txreq), .rx_data(a_rxd), .rx_valid(a_rxv),
    .busy(a_busy), .done(a_done), .qspi_clk(a_sck), .qspi_cs(a_cs),
    .qspi_io_o(a_io_o), .qspi_io_oe(a_io_oe), .qspi_io_i(a_io_i));

  edge_t       a_expe[$];
  int          a_expcnt[$];
  int          a_exptx[$];
  logic [7:0]  a_exprx[$];
  logic [3:0]  a_rdq[$];
  logic [7:0]  a_txb[16];
  int          a_txw = 0, a_txp = 0;
  int          a_rise = 0, a_txcnt = 0, a_cs_run = 0, a_bursts = 0;
  logic        a_sck_prev = 1'b0, a_cs_prev = 1'b1;

  assign a_txd = a_txb[a_txp[3:0]];
  always @(posedge clk) if (a_txreq) a_txp <= a_txp + 1;

  // Pushes the whole expected picture of one A burst (bytes MSB-first in d).
  task automatic a_expect(input bit w, input logic [31:0] ad, input int ln, input logic [23:0] d);
    edge_t e;
    logic [7:0] cmd, b;
    logic [39:0] hdr;
    cmd = w ? 8'h32 : 8'h6B;
    hdr = {cmd, ad};
    for (int i = 0; i < 10; i++) begin
      e.nib = hdr[39 - 4*i -: 4]; e.oe = 4'hF; e.cn = 1'b1; a_expe.push_back(e);
    end
    if (!w) for (int i = 0; i < 2; i++) begin
      e.nib = 4'h0; e.oe = 4'h0; e.cn = 1'b0; a_expe.push_back(e);
    end
    for (int i = 0; i < ln; i++) begin
      b = 8'(d >> (8 * (2 - i)));
      if (w) begin
        a_txb[a_txw[3:0]] = b; a_txw++;
        e.nib = b[7:4]; e.oe = 4'hF; e.cn = 1'b1; a_expe.push_back(e);
        e.nib = b[3:0]; a_expe.push_back(e);
      end else begin
        a_exprx.push_back(b);
        a_rdq.push_back(b[7:4]); a_rdq.push_back(b[3:0]);
        e.nib = 4'h0; e.oe = 4'h0; e.cn = 1'b0;
        a_expe.push_back(e); a_expe.push_back(e);
      end
    end
    a_expcnt.push_back(w ? 10 + 2*ln : 12 + 2*ln);
    a_exptx.push_back(w ? ln : 0);
  endtask

  task automatic a_pulse(input bit w, input logic [31:0] ad, input logic [7:0] ln);
    @(negedge clk);
    a_start = 1'b1; a_wr = w; a_addr = ad; a_len = ln;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_wait_idle(input string nm);
    int t;
    t = 0;
    while (a_expcnt.size() != 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    chk(nm, a_expcnt.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    edge_t e;
    if (a_sck && !a_sck_prev) begin
      a_rise++;
      if (a_expe.size() == 0) chk("A extra SCK edge", a_sck, 1'b0);
      else begin
        e = a_expe.pop_front();
        chk("A oe at rise", a_io_oe, e.oe);
        if (e.cn) chk("A io nibble at rise", a_io_o, e.nib);
      end
    end
    // responder: next read nibble goes out on the falling SCK edge
    if (!a_sck && a_sck_prev && a_rise >= 12 && a_rdq.size() > 0) a_io_i = a_rdq.pop_front();
    if (a_txreq) a_txcnt++;
    if (a_rxv) begin
      if (a_exprx.size() == 0) chk("A rx unexpected", a_rxv, 1'b0);
      else chk("A rx byte", a_rxd, a_exprx.pop_front());
    end
    if (!a_cs && a_cs_prev && a_bursts > 0) chk("A cs gap >= CLK_DIV", (a_cs_run >= 2), 1'b1);
    a_cs_run = a_cs ? a_cs_run + 1 : 0;
    if (a_done) begin
      chk("A busy during done", a_busy, 1'b1);
      if (a_expcnt.size() == 0) chk("A done unexpected", a_done, 1'b0);
      else begin
        chk("A rising edge count", a_rise, a_expcnt.pop_front());
        chk("A tx_req count", a_txcnt, a_exptx.pop_front());
      end
      a_rise = 0; a_txcnt = 0; a_bursts++;
    end
    a_sck_prev = a_sck;
    a_cs_prev  = a_cs;
  end

  // ---------------- instance B: CLK_DIV=4, DUMMY_CYCLES=0 ----------------
  logic        b_rst = 1'b1, b_start = 1'b0;
  logic [31:0] b_addr = '0;
  logic [7:0]  b_len = '0, b_rxd;
  logic [7:0]  b_txd = 8'h00;
  logic        b_txreq, b_rxv, b_busy, b_done, b_sck, b_cs;
  logic [3:0]  b_io_o, b_io_oe;
  logic [3:0]  b_io_i = 4'h0;

  qspi_master_ctrl #(.CLK_DIV(4), .DUMMY_CYCLES(0), .LEN_W(8)) dut_b (
    .clk(clk), .Rst(b_rst), .start(b_start), .wr(1'b0), .addr(b_addr), .len(b_len),
    .tx_data(b_txd), .tx_req(b_txreq), .rx_data(b_rxd), .rx_valid(b_rxv),
    .busy(b_busy), .done(b_done), .qspi_clk(b_sck), .qspi_cs(b_cs),
    .qspi_io_o(b_io_o), .qspi_io_oe(b_io_oe), .qspi_io_i(b_io_i));

  int         b_expcnt[$];
  logic [7:0] b_exprx[$];
  logic [3:0] b_rdq[$];
  int         b_rise = 0, b_act = 0;
  logic       b_sck_prev = 1'b0;

  always @(negedge clk) begin
    if (b_rst) begin
      b_rise = 0;
      b_rdq.delete();
    end else begin
      if (b_sck && !b_sck_prev) b_rise++;
      if (!b_sck && b_sck_prev && b_rise >= 10 && b_rdq.size() > 0) b_io_i = b_rdq.pop_front();
      if (b_rxv) begin
        if (b_exprx.size() == 0) chk("B rx unexpected", b_rxv, 1'b0);
        else chk("B rx byte", b_rxd, b_exprx.pop_front());
      end
      if (b_done) begin
        if (b_expcnt.size() == 0) chk("B done unexpected", b_done, 1'b0);
        else chk("B rising edge count", b_rise, b_expcnt.pop_front());
        b_rise = 0;
      end
      if (b_txreq) chk("B tx_req on read", b_txreq, 1'b0);
    end
    b_sck_prev = b_sck;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t, cs_low;
    repeat (3) @(negedge clk);
    chk("A reset cs", a_cs, 1'b1);
    chk("A reset sck", a_sck, 1'b0);
    chk("A reset io_o", a_io_o, 4'h0);
    chk("A reset oe", a_io_oe, 4'h0);
    chk("A reset busy/done/tx_req/rx_valid", {a_busy, a_done, a_txreq, a_rxv}, 4'b0000);
    chk("A reset rx_data", a_rxd, 8'h00);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // write burst: 3,2,0,0,0,0,0,0,1,0,A,5,3,C over 14 rising edges
    a_expect(1'b1, 32'h0000_0010, 2, 24'hA53C00);
    a_pulse(1'b1, 32'h0000_0010, 8'd2);
    a_wait_idle("A write burst completes");

    // read burst 31,32,33; a stray start while busy must change nothing
    a_expect(1'b0, 32'h0000_0000, 3, 24'h313233);
    a_pulse(1'b0, 32'h0000_0000, 8'd3);
    repeat (20) @(negedge clk);
    chk("A busy mid-burst", a_busy, 1'b1);
    a_pulse(1'b1, 32'hFFFF_FFF0, 8'd5);
    a_wait_idle("A read burst completes");
    chk("A rx_data holds last byte", a_rxd, 8'h33);

    // len=0 start: no CS activity, stays idle
    a_pulse(1'b1, 32'h1234_5678, 8'd0);
    cs_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!a_cs || a_busy) cs_low++;
    end
    chk("A len=0 ignored", cs_low, 0);

    // back-to-back: start held over the done cycle and the one after it
    a_expect(1'b1, 32'hDEAD_BEEF, 1, 24'h960000);
    a_pulse(1'b1, 32'hDEAD_BEEF, 8'd1);
    t = 0;
    while (!a_done && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("A done seen for first of pair", a_done, 1'b1);
    a_expect(1'b0, 32'h8000_0001, 1, 24'hC70000);
    a_start = 1'b1; a_wr = 1'b0; a_addr = 32'h8000_0001; a_len = 8'd1;
    @(negedge clk);
    chk("A busy low cycle after done", a_busy, 1'b0);
    @(negedge clk);
    a_start = 1'b0;
    a_wait_idle("A back-to-back completes");
    chk("A edge queue drained", a_expe.size(), 0);
    chk("A rx queue drained", a_exprx.size(), 0);

    // B: reset in the middle of a read data phase
    b_rdq.push_back(4'h1); b_rdq.push_back(4'h2);
    b_rdq.push_back(4'h3); b_rdq.push_back(4'h4);
    @(negedge clk);
    b_start = 1'b1; b_addr = 32'h0000_0100; b_len = 8'd2;
    @(negedge clk);
    b_start = 1'b0;
    t = 0;
    while (b_rise < 11 && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("B reached read data phase", (b_rise >= 11), 1'b1);
    b_rst = 1'b1;
    #1;
    chk("B async reset cs", b_cs, 1'b1);
    chk("B async reset sck", b_sck, 1'b0);
    chk("B async reset oe", b_io_oe, 4'h0);
    chk("B async reset busy", b_busy, 1'b0);
    @(negedge clk);
    b_rst = 1'b0;
    b_act = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (b_rxv || b_done || b_txreq || !b_cs) b_act++;
    end
    chk("B quiet after reset", b_act, 0);

    // B: zero-dummy read of one byte 5A, 12 rising edges
    b_rdq.push_back(4'h5); b_rdq.push_back(4'hA);
    b_exprx.push_back(8'h5A);
    b_expcnt.push_back(12);
    @(negedge clk);
    b_start = 1'b1; b_addr = 32'h0000_0040; b_len = 8'd1;
    @(negedge clk);
    b_start = 1'b0;
    t = 0;
    while (b_expcnt.size() != 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("B zero-dummy read completes", b_expcnt.size(), 0);
    chk("B rx_data after read", b_rxd, 8'h5A);
    chk("B rx queue drained", b_exprx.size(), 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
